// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multicycle mult/div unit owning the HI/LO pair; fixed 34-cycle latency.
// Define MULDIV_SIGNED_EN to enable signed mult/div; otherwise mult/div act as multu/divu.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic               is_div;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               in_sa, in_sb, neg_q, neg_r;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
    logic [WIDTH:0]     add_s, sub_d;
    logic [2*WIDTH-1:0] step, prod;

`ifdef MULDIV_SIGNED_EN
    logic s_a, s_b;
    assign in_sa = ~op[0] & A[WIDTH-1];
    assign in_sb = ~op[0] & B[WIDTH-1];
    always_ff @(posedge clk)
        if (reset) {s_a, s_b} <= '0;
        else if (state == IDLE && start) {s_a, s_b} <= {in_sa, in_sb};
    assign neg_q = s_a ^ s_b;
    assign neg_r = s_a;
`else
    assign in_sa = 1'b0;
    assign in_sb = 1'b0;
    assign neg_q = 1'b0;
    assign neg_r = 1'b0;
`endif

    assign abs_a = in_sa ? -A : A;
    assign abs_b = in_sb ? -B : B;
    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
    assign add_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
    assign sub_d = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_r};
    assign step  = is_div ? (sub_d[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                          : {sub_d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                          : {add_s, acc[WIDTH-1:1]};
    assign prod  = neg_q ? -acc : acc;
    // A zero divisor leaves remainder = |A|, so HI recovers A after sign fix-up; LO is forced
    assign quo   = (b_r == '0) ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            is_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        is_div <= op[1];
                        a_r    <= abs_a;
                        b_r    <= abs_b;
                        acc    <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                        cnt    <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    {hi, lo} <= is_div ? {rem, quo} : prod;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and random checks of hilo_muldiv_unit against an arithmetic model.
module tb_hilo_muldiv_unit;
    logic        clk = 0, reset = 1, start = 0, mthi = 0, mtlo = 0;
    logic [1:0]  op = 0;
    logic [31:0] A = 0, B = 0, wdata = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          n_chk = 0, n_fail = 0;
`ifdef MULDIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit s = SGN && !o[0];
        longint sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        longint sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o[1]) return 64'(sa * sb);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic wait_done(output int k);
        k = 1;
        while (!done && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    // k counts edges from the start-sampling edge (k=1) to the edge that raises done
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int k, output bit held);
        logic [63:0] prev;
        @(negedge clk);
        prev = {hi, lo};
        op = o; A = a; B = b; start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_after_start", busy, 1);
        k = 1; held = 1;
        while (!done && k < 60) begin
            if ({hi, lo} !== prev) held = 0;
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic run_chk(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int k; bit held;
        do_op(o, a, b, k, held);
        check({tag, "_lat"}, k, 34);
        check({tag, "_res"}, {hi, lo}, model(o, a, b));
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int k, ndone;
        bit held;
        logic [31:0] ra, rb;
        logic [1:0] ro;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hilo", {hi, lo}, 0);
        check("reset_flags", {busy, done}, 0);
        @(negedge clk); reset = 0;

        @(negedge clk); mthi = 1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1; mthi = 0;
        check("mthi_idle", hi, 32'hA5A5_A5A5);
        @(negedge clk); mthi = 1; mtlo = 1; wdata = 32'h1234_5678;
        @(posedge clk); #1; mthi = 0; mtlo = 0;
        check("mthi_mtlo_both", {hi, lo}, 64'h1234_5678_1234_5678);

        run_chk("multu_max", 2'b01, 32'hFFFF_FFFF, 2);
        check("multu_max_k", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_chk("mult_neg", 2'b00, 32'hFFFF_FFFD, 5);
        check("mult_neg_k", {hi, lo}, SGN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1);
        run_chk("divu_100_7", 2'b11, 100, 7);
        check("divu_100_7_k", {hi, lo}, {32'd2, 32'd14});
        run_chk("div_m7_2", 2'b10, 32'hFFFF_FFF9, 2);
        check("div_m7_2_k", {hi, lo}, SGN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'h0000_0001_7FFF_FFFC);
        run_chk("div_by_zero", 2'b10, 32'h1234_5678, 0);
        check("div_by_zero_k", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
        run_chk("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_k", {hi, lo}, SGN ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000);

        // Back-to-back: the second start lands in the first op's done cycle
        do_op(2'b11, 100, 7, k, held);
        check("b2b_first_lat", k, 34);
        do_op(2'b01, 32'h0001_0000, 32'h0001_0000, k, held);
        check("b2b_second_lat", k, 34);
        check("b2b_held", held, 1);
        check("b2b_res", {hi, lo}, 64'h0000_0001_0000_0000);

        // Start while busy is ignored
        @(negedge clk); op = 2'b01; A = 6; B = 7; start = 1;
        @(posedge clk); #1; start = 0;
        ndone = 0;
        for (int i = 1; i < 80; i++) begin
            if (i == 5) begin
                @(negedge clk); A = 9; B = 9; start = 1;
                @(posedge clk); #1; start = 0;
            end else begin
                @(posedge clk); #1;
            end
            if (done) ndone++;
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_res", {hi, lo}, 64'd42);

        // mthi with start applies at once; mthi/mtlo while busy are dropped
        @(negedge clk); op = 2'b01; A = 3; B = 3; start = 1; mthi = 1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1; start = 0; mthi = 0;
        check("start_mthi_hi", hi, 32'hCAFE_F00D);
        repeat (8) @(posedge clk);
        @(negedge clk); mthi = 1; mtlo = 1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1; mthi = 0; mtlo = 0;
        check("mthi_busy_ignored", hi, 32'hCAFE_F00D);
        wait_done(k);
        check("mthi_busy_done", done, 1);
        check("mthi_busy_res", {hi, lo}, 64'd9);

        // Reset in the middle of an operation
        @(negedge clk); op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        check("midreset_flags", {busy, done}, 0);
        check("midreset_hilo", {hi, lo}, 0);
        @(negedge clk); reset = 0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midreset_no_done", ndone, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_chk($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
